// File: rtl/example_acc_pkg.sv
// Shared widths, saturation limits and a clog2 helper for the accumulate/requantize
// layer stages.
package example_acc_pkg;

  localparam int DIN_WIDTH  = 21;
  localparam int ACC_WIDTH  = 24;
  localparam int DOUT_WIDTH = 16;

  localparam logic signed [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/example_requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic right shift by SHIFT, then
// saturate to a signed DOUT_W result with a flag.
module example_requant_sat #(
  parameter int ACC_W  = example_acc_pkg::ACC_WIDTH,
  parameter int DOUT_W = example_acc_pkg::DOUT_WIDTH,
  parameter int SHIFT  = 6
) (
  input  logic signed [ACC_W-1:0]  sum_i,
  output logic signed [DOUT_W-1:0] q_o,
  output logic                     sat_o
);

  localparam int EW = ACC_W + 1;

  // Limits sign-extended to the working width so the compare is a plain signed compare.
  localparam logic signed [EW-1:0] MAX_V = {{(EW+1-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW+1-DOUT_W){1'b1}}, {(DOUT_W-1){1'b0}}};

  logic signed [EW-1:0] ext_w;
  logic signed [EW-1:0] rnd_w;
  logic signed [EW-1:0] shr_w;

  assign ext_w = {sum_i[ACC_W-1], sum_i};

  generate
    if (SHIFT == 0) begin : g_no_round
      assign rnd_w = ext_w;
    end else begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
      assign rnd_w = ext_w + HALF;
    end
  endgenerate

  assign shr_w = rnd_w >>> SHIFT;

  always_comb begin
    sat_o = 1'b0;
    q_o   = shr_w[DOUT_W-1:0];
    if (shr_w > MAX_V) begin
      q_o   = MAX_V[DOUT_W-1:0];
      sat_o = 1'b1;
    end else if (shr_w < MIN_V) begin
      q_o   = MIN_V[DOUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/example_mac_acc_requant.sv
// Sums N_TERMS signed products into one dot product, requantizes it and offers it
// through a single-entry output register.
module example_mac_acc_requant #(
  parameter int DIN_WIDTH  = example_acc_pkg::DIN_WIDTH,
  parameter int N_TERMS    = 4,
  parameter int ACC_WIDTH  = example_acc_pkg::ACC_WIDTH,
  parameter int SHIFT      = 6,
  parameter int DOUT_WIDTH = example_acc_pkg::DOUT_WIDTH
) (
  input  logic                                         ap_clk,
  input  logic                                         ap_rst,
  input  logic signed [DIN_WIDTH-1:0]                  din,
  input  logic                                         din_vld,
  output logic                                         din_rdy,
  output logic signed [DOUT_WIDTH-1:0]                 dout,
  output logic                                         dout_vld,
  input  logic                                         dout_rdy,
  output logic                                         dout_sat,
  output logic [example_acc_pkg::clog2(N_TERMS)-1:0]   grp_cnt
);

  import example_acc_pkg::*;

  localparam int CNT_W = clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  // Output register occupancy; dout_vld is this state.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0]  din_ext_w;
  logic signed [ACC_WIDTH-1:0]  sum_w;
  logic signed [DOUT_WIDTH-1:0] rq_w;
  logic                         rq_sat_w;
  logic                         is_last_w;
  logic                         in_fire_w;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both
  // high; valid holds its data until then. Only the final term of a group waits on
  // the output register, so a held result is never overwritten.
  assign is_last_w = (cnt_q == LAST_IDX);
  assign dout_vld  = (state_q == ST_FULL);
  assign din_rdy   = !is_last_w || !dout_vld || dout_rdy;
  assign in_fire_w = din_vld && din_rdy;

  assign din_ext_w = {{(ACC_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
  assign sum_w     = acc_q + din_ext_w;

  example_requant_sat #(
    .ACC_W  (ACC_WIDTH),
    .DOUT_W (DOUT_WIDTH),
    .SHIFT  (SHIFT)
  ) u_requant (
    .sum_i (sum_w),
    .q_o   (rq_w),
    .sat_o (rq_sat_w)
  );

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    if (in_fire_w) begin
      if (is_last_w) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A new result loading takes priority over draining the old one.
    if (in_fire_w && is_last_w) begin
      state_d = ST_FULL;
      dout_d  = rq_w;
      sat_d   = rq_sat_w;
    end else if (dout_vld && dout_rdy) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign dout     = dout_q;
  assign dout_sat = sat_q;
  assign grp_cnt  = cnt_q;

endmodule

// File: tb/tb_example_mac_acc_requant.sv
// Bench for example_mac_acc_requant: directed steps plus a randomized phase, all
// results checked against a group-sum reference model.
module tb_example_mac_acc_requant;

  localparam int DW = 21;
  localparam int OW = 16;
  localparam int NT = 4;
  localparam int SH = 6;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic                 din_vld = 1'b0;
  logic                 din_rdy;
  logic signed [OW-1:0] dout;
  logic                 dout_vld;
  logic                 dout_rdy = 1'b0;
  logic                 dout_sat;
  logic [1:0]           grp_cnt;

  int tests = 0;
  int fails = 0;
  int results = 0;

  // Expected results: {sat, dout}
  logic [OW:0] exp_q[$];
  longint      part_sum = 0;
  int          part_n = 0;
  logic        drv_done = 1'b0;

  example_mac_acc_requant dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout_sat (dout_sat),
    .grp_cnt  (grp_cnt)
  );

  // ---------------- clock ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checks and reference model ----------------
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Round half up, shift, saturate, computed with ordinary integer arithmetic.
  function automatic logic [OW:0] model(input longint s);
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    r  = floor_div(s + (longint'(1) << (SH - 1)), longint'(1) << SH);
    if (r > hi) return {1'b1, 1'b0, {(OW-1){1'b1}}};
    if (r < lo) return {1'b1, 1'b1, {(OW-1){1'b0}}};
    return {1'b0, OW'(r)};
  endfunction

  function automatic logic signed [DW-1:0] rand_prod();
    int a;
    int b;
    a = int'($urandom_range(0, 16383)) - 8192;
    b = int'($urandom_range(0, 127));
    return DW'(a * b);
  endfunction

  // Scoreboard: every held result must equal the head of exp_q; terms that will
  // transfer on the coming edge are folded into the model's group sum.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result observed=%0d expected=none", $signed(dout));
        end else begin
          chk("out_dout", $signed(dout), $signed(exp_q[0][OW-1:0]));
          chk("out_sat", dout_sat, exp_q[0][OW]);
          if (dout_rdy) begin
            void'(exp_q.pop_front());
            results++;
          end
        end
      end
      if (din_vld && din_rdy) begin
        part_sum += longint'(din);
        part_n++;
        if (part_n == NT) begin
          exp_q.push_back(model(part_sum));
          part_sum = 0;
          part_n   = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic put_term(input logic signed [DW-1:0] v);
    int   budget;
    logic ok;
    budget  = 60;
    din     = v;
    din_vld = 1'b1;
    ok      = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge ap_clk);
      ok = din_rdy;
      @(posedge ap_clk);
      budget--;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL put_term_timeout observed=no_handshake expected=handshake");
    end
    #1;
    din_vld = 1'b0;
  endtask

  // ---------------- directed and random sequence ----------------
  logic signed [DW-1:0] v [8];
  logic [OW:0]          e1;
  logic [OW:0]          e2;
  longint               s1;
  longint               s2;
  int                   r0;

  initial begin
    // Reset state
    ap_rst = 1'b1;
    idle(2);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_grp_cnt", grp_cnt, 0);
    chk("rst_dout", $signed(dout), 0);
    chk("rst_dout_sat", dout_sat, 0);
    ap_rst = 1'b0;
    idle(1);
    chk("rst_din_rdy", din_rdy, 1);

    // Basic group: 4 x 100 -> 6
    dout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) put_term(21'sd100);
    chk("basic_pre_vld", dout_vld, 0);
    put_term(21'sd100);
    chk("basic_vld", dout_vld, 1);
    chk("basic_dout", $signed(dout), 6);
    chk("basic_sat", dout_sat, 0);
    chk("basic_cnt", grp_cnt, 0);
    idle(1);
    chk("basic_drained", dout_vld, 0);

    // Rounding ties
    for (int i = 0; i < 4; i++) put_term(21'sd24);
    chk("tie_pos", $signed(dout), 2);
    for (int i = 0; i < 4; i++) put_term(-21'sd24);
    chk("tie_neg", $signed(dout), -1);

    // Saturation
    for (int i = 0; i < 4; i++) put_term(21'sd1040257);
    chk("sat_pos_dout", $signed(dout), 32767);
    chk("sat_pos_flag", dout_sat, 1);
    for (int i = 0; i < 4; i++) put_term(-21'sd1040384);
    chk("sat_neg_dout", $signed(dout), -32768);
    chk("sat_neg_flag", dout_sat, 1);
    idle(2);

    // Backpressure: 8 products with the output stalled
    for (int i = 0; i < 8; i++) v[i] = rand_prod();
    s1 = 0;
    s2 = 0;
    for (int i = 0; i < 4; i++) s1 += longint'(v[i]);
    for (int i = 4; i < 8; i++) s2 += longint'(v[i]);
    e1 = model(s1);
    e2 = model(s2);
    r0 = results;
    dout_rdy = 1'b0;
    for (int i = 0; i < 7; i++) put_term(v[i]);
    chk("bp_first_vld", dout_vld, 1);
    chk("bp_first_dout", $signed(dout), $signed(e1[OW-1:0]));
    chk("bp_cnt3", grp_cnt, 3);
    chk("bp_rdy_low", din_rdy, 0);
    din     = v[7];
    din_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("bp_rdy_held_low", din_rdy, 0);
      chk("bp_dout_held", $signed(dout), $signed(e1[OW-1:0]));
      chk("bp_sat_held", dout_sat, e1[OW]);
    end
    dout_rdy = 1'b1;
    put_term(v[7]);
    chk("bp_second_vld", dout_vld, 1);
    chk("bp_second_dout", $signed(dout), $signed(e2[OW-1:0]));
    chk("bp_second_sat", dout_sat, e2[OW]);
    chk("bp_cnt_wrap", grp_cnt, 0);
    idle(1);
    chk("bp_count", results - r0, 2);
    chk("bp_drained", dout_vld, 0);

    // Simultaneous load and drain on the same edge
    for (int i = 0; i < 8; i++) v[i] = rand_prod();
    s2 = 0;
    for (int i = 4; i < 8; i++) s2 += longint'(v[i]);
    e2 = model(s2);
    r0 = results;
    for (int i = 0; i < 4; i++) put_term(v[i]);
    dout_rdy = 1'b0;
    for (int i = 4; i < 7; i++) put_term(v[i]);
    dout_rdy = 1'b1;
    put_term(v[7]);
    chk("ld_vld_kept", dout_vld, 1);
    chk("ld_new_dout", $signed(dout), $signed(e2[OW-1:0]));
    idle(1);
    chk("ld_count", results - r0, 2);
    chk("ld_drained", dout_vld, 0);

    // Reset mid-group with a pending result
    dout_rdy = 1'b0;
    for (int i = 0; i < 6; i++) put_term(rand_prod());
    chk("mrst_pre_cnt", grp_cnt, 2);
    chk("mrst_pre_vld", dout_vld, 1);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("mrst_vld", dout_vld, 0);
    chk("mrst_cnt", grp_cnt, 0);
    chk("mrst_dout", $signed(dout), 0);
    exp_q.delete();
    part_sum = 0;
    part_n   = 0;
    idle(2);
    ap_rst = 1'b0;
    idle(1);
    dout_rdy = 1'b1;
    chk("mrst_no_output", dout_vld, 0);
    for (int i = 0; i < 4; i++) put_term(21'sd64);
    chk("mrst_fresh_dout", $signed(dout), 4);
    chk("mrst_fresh_sat", dout_sat, 0);
    idle(3);
    chk("mrst_single", dout_vld, 0);

    // Random phase: random products, gaps and downstream stalls
    fork
      begin
        for (int g = 0; g < 20; g++) begin
          for (int t = 0; t < NT; t++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            put_term(rand_prod());
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge ap_clk);
          #1;
          if (!drv_done) dout_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    dout_rdy = 1'b1;
    idle(5);
    chk("rand_all_drained", exp_q.size(), 0);
    chk("rand_vld_idle", dout_vld, 0);
    chk("rand_cnt_idle", grp_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
